driver_piso_chain: RTL
======================

Name: driver_piso_chain

Overview:
Parametrised reader for daisy-chained parallel-in/serial-out shift registers (74LV165 class), one serial line per channel. It generates SH_LDn and RCLK at a programmable rate and deserialises NUM_CH channels of CHAIN_BITS each in parallel. Each channel has a frame-level debounce. The block adds a start/stop enable and pulses for frame-complete and data-changed. It sits in the shell, between the board-level switch/panel shift chains and the core's input registers.

Parameters:
NUM_CH, 5, number of parallel serial channels (>=1).
CHAIN_BITS, 16, bits per channel per frame (chained chips x 8; >=2).
CLK_DIV, 1, clk cycles per half bit period (>=1).
DEBOUNCE, 2, consecutive identical raw frames required before a channel's output updates (>=1; 1 = no filtering).
MSB_FIRST, 1, 1: first sampled bit lands in bit CHAIN_BITS-1 (shift left); 0: first sampled bit lands in bit 0.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
enable  input  1  run continuous scanning while high
data  output  NUM_CH*CHAIN_BITS  debounced data; channel c occupies [c*CHAIN_BITS +: CHAIN_BITS]
frame_valid  output  1  1-cycle pulse when a raw frame has been captured
changed  output  1  1-cycle pulse when any channel's data output took a new value
SH_LDn  output  1  to chips; low = parallel load, high = shift
RCLK  output  1  to chips; shift clock, rising edge shifts
QH  input  NUM_CH  serial data from each chain

Behaviour:
- Reset is applied on any clk edge with resetn=0, including mid-frame. Reset values: data=0, frame_valid=0, changed=0, SH_LDn=1, RCLK=0, state=IDLE, all shift, raw and debounce state cleared.
- tick: a strobe asserted once every CLK_DIV clk cycles. The divider counter is held at 0 in IDLE. All phase changes happen only on tick.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE: SH_LDn=1, RCLK=0. Moves to LOAD on the first clk with enable=1.
- LOAD: SH_LDn=0 and RCLK=0 for 2 ticks, then SHIFT with bit counter=0.
- SHIFT: each bit takes 2 ticks.
  - Phase 0: RCLK=0. At the end of phase 0, sample QH[c] into shift register c (MSB_FIRST selects the shift direction).
  - Phase 1: RCLK=1.
  - After phase 1 of bit CHAIN_BITS-1, the frame is complete:
    - raw = shift registers, and frame_valid pulses on the next cycle;
    - if enable=1, go to LOAD; otherwise go to IDLE.
- Frame period = 2*(CHAIN_BITS+1)*CLK_DIV clk cycles. This is 34 cycles with the defaults.
- Deasserting enable mid-frame does not abort the frame. The frame completes and its result is delivered.
- Debounce is per channel:
  - The stable count saturates at DEBOUNCE-1.
  - On frame completion, if the new raw value equals the previous raw value, increment the count; otherwise reset it to 0.
  - When the count (after update) equals DEBOUNCE-1, load data[c] from raw.
  - With DEBOUNCE=1, data tracks every frame.
  - After reset the previous raw value is 0, so constant input V appears after DEBOUNCE frames.
- data updates in the same cycle that frame_valid pulses.
- changed pulses in that same cycle only if at least one channel's data value differs from its prior value.
- Counter widths: $clog2-sized, and wide enough for CHAIN_BITS, CLK_DIV and DEBOUNCE at their maximum values.

Decomposition:
- Shared shell package/include: FSM state encodings (IDLE/LOAD/SHIFT) and the $clog2 width helpers.
- One sub-module, piso_ch_debounce, instantiated NUM_CH times. Inputs: frame-done strobe and raw word. Outputs: debounced word and changed bit. The top level handles timing, the FSM and the shift registers.

Test Plan:
1. Defaults, enable=1, all 5 chains model 16-bit '165s loaded with 0xA5C3 -> RCLK has 16 rising edges per frame and SH_LDn is low for 2 cycles per 34-cycle frame. data ch0=0xA5C3 after the 2nd frame_valid, and changed pulses once.
2. DEBOUNCE=3, input alternates 0x0001/0x0002 each frame, then holds 0x0004 -> data stays 0 during alternation and becomes 0x0004 on the 3rd identical frame.
3. MSB_FIRST=0, CHAIN_BITS=8, CLK_DIV=3, chip loaded 0x80 -> data=0x01. Each RCLK level lasts 3 clk cycles, and the frame is 54 cycles.
4. enable dropped at bit 5 -> the frame completes, frame_valid pulses, and the FSM returns to IDLE with SH_LDn=1 and RCLK=0. Re-asserting enable starts LOAD on the next cycle.
5. resetn pulsed low mid-SHIFT -> on the next edge, data=0, SH_LDn=1 and RCLK=0. A subsequent scan needs DEBOUNCE full frames to republish the data.
6. Stable input across 10 frames -> frame_valid pulses every frame, and changed pulses only once.

Source files
------------

// File: rtl/driver_piso_chain_pkg.sv
// Shared definitions for the PISO chain reader: scan FSM encoding and counter width helper.
package driver_piso_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } piso_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/driver_piso_chain_debounce.sv
// Per-channel frame debounce: publishes a raw word once it has been seen DEBOUNCE frames in a row.
module piso_ch_debounce
    import driver_piso_chain_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             frame_done_i,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] data_o,
    output logic             changed_o
);

    localparam int unsigned    CNT_W    = cnt_w(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] raw_q, raw_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d;

    // Stable count saturates at DEBOUNCE-1; publish whenever it sits there after a frame.
    always_comb begin
        raw_d  = raw_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        chg_d  = 1'b0;
        if (frame_done_i) begin
            raw_d = raw_i;
            if (raw_i != raw_q) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == CNT_LAST) begin
                data_d = raw_i;
                chg_d  = (raw_i != data_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            raw_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            raw_q  <= raw_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            chg_q  <= chg_d;
        end
    end

    assign data_o    = data_q;
    assign changed_o = chg_q;

endmodule

// File: rtl/driver_piso_chain.sv
// Scanner for daisy-chained '165-class shift registers: drives SH_LDn/RCLK and deserialises NUM_CH lines.
module driver_piso_chain
    import driver_piso_chain_pkg::*;
#(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned CHAIN_BITS = 16,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned DEBOUNCE   = 2,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         enable,
    output logic [NUM_CH*CHAIN_BITS-1:0] data,
    output logic                         frame_valid,
    output logic                         changed,
    output logic                         SH_LDn,
    output logic                         RCLK,
    input  logic [NUM_CH-1:0]            QH
);

    localparam int unsigned      DIV_W    = cnt_w(CLK_DIV);
    localparam int unsigned      BIT_W    = cnt_w(CHAIN_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_BITS - 1);

    piso_state_e state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             ph_q, ph_d;
    logic             sh_ldn_q, sh_ldn_d;
    logic             rclk_q, rclk_d;
    logic             fv_q;

    logic [NUM_CH-1:0][CHAIN_BITS-1:0] sr_q, sr_d;
    logic [NUM_CH-1:0]                 chg_vec;

    logic tick_c, sample_c, done_c;

    // Rate divider; parked at zero while idle so every frame starts phase-aligned.
    assign tick_c   = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    assign sample_c = tick_c && (state_q == ST_SHIFT) && !ph_q;
    assign done_c   = tick_c && (state_q == ST_SHIFT) && ph_q && (bit_q == BIT_LAST);
    assign div_d    = ((state_q == ST_IDLE) || tick_c) ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
        end
    end

    // Next state: two ticks of LOAD, then two ticks per bit; a stop request only takes effect at frame end.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                ph_d  = 1'b0;
                bit_d = '0;
                if (enable) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (tick_c) begin
                    if (ph_q) begin
                        state_d = ST_SHIFT;
                        ph_d    = 1'b0;
                        bit_d   = '0;
                    end else begin
                        ph_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (tick_c) begin
                    if (!ph_q) begin
                        ph_d = 1'b1;
                    end else begin
                        ph_d = 1'b0;
                        if (bit_q == BIT_LAST) begin
                            bit_d   = '0;
                            state_d = enable ? ST_LOAD : ST_IDLE;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ph_d    = 1'b0;
                bit_d   = '0;
            end
        endcase
    end

    // Chip controls are decoded from the next state so the registered pins track the FSM exactly.
    always_comb begin
        sh_ldn_d = 1'b1;
        rclk_d   = 1'b0;
        if (state_d == ST_LOAD) begin
            sh_ldn_d = 1'b0;
        end
        if ((state_d == ST_SHIFT) && ph_d) begin
            rclk_d = 1'b1;
        end
    end

    always_comb begin
        sr_d = sr_q;
        if (sample_c) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (MSB_FIRST) begin
                    sr_d[c] = {sr_q[c][CHAIN_BITS-2:0], QH[c]};
                end else begin
                    sr_d[c] = {QH[c], sr_q[c][CHAIN_BITS-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr_q     <= '0;
            fv_q     <= 1'b0;
            sh_ldn_q <= 1'b1;
            rclk_q   <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            fv_q     <= done_c;
            sh_ldn_q <= sh_ldn_d;
            rclk_q   <= rclk_d;
        end
    end

    // The shift registers are complete at frame end, so they feed the filters directly as the raw word.
    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        piso_ch_debounce #(
            .WIDTH    (CHAIN_BITS),
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clk          (clk),
            .resetn       (resetn),
            .frame_done_i (done_c),
            .raw_i        (sr_q[c]),
            .data_o       (data[c*CHAIN_BITS +: CHAIN_BITS]),
            .changed_o    (chg_vec[c])
        );
    end

    assign frame_valid = fv_q;
    assign changed     = |chg_vec;
    assign SH_LDn      = sh_ldn_q;
    assign RCLK        = rclk_q;

endmodule
